// File: rtl/mantissa_shift_unit_pkg.sv
// Shared types for the mantissa shift unit: FSM states and operation modes.
package mantissa_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALIGN = 2'b01,
        NORM  = 2'b10,
        DONE  = 2'b11
    } state_t;

    // 2'b11 is not named; it decodes as load-only like MODE_LOAD.
    typedef enum logic [1:0] {
        MODE_ALIGN = 2'b00,
        MODE_NORM  = 2'b01,
        MODE_LOAD  = 2'b10
    } mode_t;

endpackage

// File: rtl/mantissa_shift_unit_if.sv
// Command/result bundle of the mantissa shift unit.
interface mantissa_shift_unit_if #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] parin_mantice;
    logic [CNT_W-1:0] shamt;
    logic             serin_from_left;
    logic [WIDTH-1:0] mantice_out;
    logic [2:0]       grs;
    logic [CNT_W-1:0] shift_cnt;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output start, mode, parin_mantice, shamt, serin_from_left,
        input  mantice_out, grs, shift_cnt, busy, done, zero
    );

    modport slave (
        input  start, mode, parin_mantice, shamt, serin_from_left,
        output mantice_out, grs, shift_cnt, busy, done, zero
    );
endinterface

// File: rtl/mantissa_shift_unit_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module mantissa_lzc #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0]               val,
    output logic [$clog2(WIDTH+1)-1:0]     lz_cnt
);
    localparam int LZ_W = $clog2(WIDTH+1);

    // Scan upward so the highest set bit determines the count.
    always_comb begin
        lz_cnt = LZ_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (val[i]) lz_cnt = LZ_W'(WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/mantissa_shift_unit.sv
// Multi-cycle mantissa aligner/normalizer with guard/round/sticky tracking.
module mantissa_shift_unit
    import mantissa_shift_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int STEP  = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mantissa_shift_unit_if.slave   bus
);
    localparam int          LZ_W   = $clog2(WIDTH+1);
    localparam int          W2     = WIDTH + 2;
    localparam int unsigned STEP_U = STEP;
    localparam logic [W2-1:0] ONES = '1;

    state_t            state;
    logic [WIDTH-1:0]  mant;
    logic              g, r, s;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  rem;
    logic              fill;
    logic              busy_q, done_q, zero_q;

    logic [LZ_W-1:0]   lz;
    logic [W2-1:0]     ext, r_ext, l_ext;
    logic              r_lost;
    logic [31:0]       k_align, k_norm, k_sel;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    assign ext = {mant, g, r};

    mantissa_lzc #(.WIDTH(WIDTH)) u_lzc (
        .val    (mant),
        .lz_cnt (lz)
    );

    // Per-cycle shift distances, each capped at STEP.
    always_comb begin
        k_align = (32'(rem) < STEP_U) ? 32'(rem) : STEP_U;
        k_norm  = (32'(lz)  < STEP_U) ? 32'(lz)  : STEP_U;
    end

    // STEP-limited shifters: a small mux over 1..STEP positions, never a full barrel.
    always_comb begin
        r_ext  = ext;
        r_lost = 1'b0;
        l_ext  = ext;
        for (int unsigned j = 1; j <= STEP_U; j++) begin
            if (k_align == j) begin
                r_ext  = (ext >> j) | (fill ? ~(ONES >> j) : '0);
                r_lost = |(ext & ~(ONES << j));
            end
            if (k_norm == j) l_ext = ext << j;
        end
    end

    // Shift count accumulation, saturating at all-ones.
    always_comb begin
        k_sel    = (state == ALIGN) ? k_align : k_norm;
        cnt_sum  = {1'b0, cnt} + (CNT_W+1)'(k_sel);
        cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Control FSM with registered outputs. The final shift moves straight to DONE
    // (and zero-shift align skips ALIGN) so done lands ceil(shamt/STEP)+1 cycles
    // after the start edge; done is raised as DONE returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mant   <= '0;
            g      <= 1'b0;
            r      <= 1'b0;
            s      <= 1'b0;
            cnt    <= '0;
            rem    <= '0;
            fill   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mant   <= bus.parin_mantice;
                        g      <= 1'b0;
                        r      <= 1'b0;
                        s      <= 1'b0;
                        cnt    <= '0;
                        rem    <= bus.shamt;
                        fill   <= bus.serin_from_left;
                        zero_q <= 1'b0;
                        busy_q <= 1'b1;
                        case (mode_t'(bus.mode))
                            MODE_ALIGN: state <= (bus.shamt == '0) ? DONE : ALIGN;
                            MODE_NORM:  state <= NORM;
                            default:    state <= DONE;
                        endcase
                    end
                end
                ALIGN: begin
                    if (rem == '0) begin
                        state <= DONE;
                    end else begin
                        {mant, g, r} <= r_ext;
                        s            <= s | r_lost;
                        rem          <= rem - CNT_W'(k_align);
                        cnt          <= cnt_next;
                        if (32'(rem) == k_align) state <= DONE;
                    end
                end
                NORM: begin
                    if (mant == '0 && !g && !r) begin
                        zero_q <= 1'b1;
                        state  <= DONE;
                    end else if (mant[WIDTH-1]) begin
                        state <= DONE;
                    end else begin
                        {mant, g, r} <= l_ext;
                        cnt          <= cnt_next;
                        if (l_ext[W2-1]) state <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mantice_out = mant;
    assign bus.grs         = {g, r, s};
    assign bus.shift_cnt   = cnt;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.zero        = zero_q;
endmodule

// File: tb/tb_mantissa_shift_unit.sv
// Directed, table-driven bench for mantissa_shift_unit.
module tb_mantissa_shift_unit;
    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    mantissa_shift_unit_if #(.WIDTH(24), .CNT_W(8)) bus ();
    mantissa_shift_unit_if #(.WIDTH(24), .CNT_W(3)) bus2 ();

    mantissa_shift_unit #(.WIDTH(24), .STEP(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-count instance used only to reach shift_cnt saturation.
    mantissa_shift_unit #(.WIDTH(24), .STEP(4), .CNT_W(3)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] parin;
        logic [7:0]  shamt;
        logic        fill;
        int          lat;
        logic [23:0] mant;
        logic [2:0]  grs;
        logic [7:0]  cnt;
        logic        zero;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation and check latency, results, and the done pulse shape.
    task automatic run_op(input string tag, input vec_t v);
        int c;
        @(negedge clk);
        bus.mode            = v.mode;
        bus.parin_mantice   = v.parin;
        bus.shamt           = v.shamt;
        bus.serin_from_left = v.fill;
        bus.start           = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        c = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            c = i;
            if (bus.done) break;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, "_lat"}, 32'(c), 32'(v.lat));
        chk({tag, "_mant"}, 32'(bus.mantice_out), 32'(v.mant));
        chk({tag, "_grs"}, 32'(bus.grs), 32'(v.grs));
        chk({tag, "_cnt"}, 32'(bus.shift_cnt), 32'(v.cnt));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(v.zero));
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, 32'(bus.mantice_out), 32'(v.mant));
    endtask

    initial begin
        int c;
        vec_t v;
        n_cmp = 0;
        n_bad = 0;

        //         mode   parin        shamt  fill lat mant         grs     cnt    zero
        vecs[0]  = '{2'b00, 24'h800001, 8'd10, 1'b1, 4,  24'hFFE000, 3'b001, 8'd10, 1'b0};
        vecs[1]  = '{2'b01, 24'h000300, 8'd0,  1'b0, 5,  24'hC00000, 3'b000, 8'd14, 1'b0};
        vecs[2]  = '{2'b01, 24'h000000, 8'd0,  1'b0, 2,  24'h000000, 3'b000, 8'd0,  1'b1};
        vecs[3]  = '{2'b00, 24'hFFFFFF, 8'd40, 1'b0, 11, 24'h000000, 3'b001, 8'd40, 1'b0};
        vecs[4]  = '{2'b00, 24'h123456, 8'd0,  1'b1, 1,  24'h123456, 3'b000, 8'd0,  1'b0};
        vecs[5]  = '{2'b10, 24'hABCDEF, 8'd5,  1'b1, 1,  24'hABCDEF, 3'b000, 8'd0,  1'b0};
        vecs[6]  = '{2'b11, 24'h5A5A5A, 8'd9,  1'b0, 1,  24'h5A5A5A, 3'b000, 8'd0,  1'b0};
        vecs[7]  = '{2'b01, 24'h800000, 8'd0,  1'b0, 2,  24'h800000, 3'b000, 8'd0,  1'b0};
        vecs[8]  = '{2'b00, 24'h000007, 8'd2,  1'b0, 2,  24'h000001, 3'b110, 8'd2,  1'b0};
        vecs[9]  = '{2'b00, 24'h000007, 8'd4,  1'b1, 2,  24'hF00000, 3'b011, 8'd4,  1'b0};
        vecs[10] = '{2'b00, 24'h000020, 8'd5,  1'b0, 3,  24'h000001, 3'b000, 8'd5,  1'b0};
        vecs[11] = '{2'b01, 24'h000001, 8'd0,  1'b0, 7,  24'h800000, 3'b000, 8'd23, 1'b0};

        rst                  = 1'b0;
        bus.start            = 1'b0;
        bus.mode             = 2'b00;
        bus.parin_mantice    = '0;
        bus.shamt            = '0;
        bus.serin_from_left  = 1'b0;
        bus2.start           = 1'b0;
        bus2.mode            = 2'b00;
        bus2.parin_mantice   = '0;
        bus2.shamt           = '0;
        bus2.serin_from_left = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mant", 32'(bus.mantice_out), 32'd0);
        chk("rst_grs",  32'(bus.grs), 32'd0);
        chk("rst_cnt",  32'(bus.shift_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        bus.mode            = 2'b00;
        bus.parin_mantice   = 24'h800001;
        bus.shamt           = 8'd10;
        bus.serin_from_left = 1'b1;
        bus.start           = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        c = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            c = i;
            if (i == 1) begin
                bus.mode            = 2'b10;
                bus.parin_mantice   = 24'h0F0F0F;
                bus.serin_from_left = 1'b0;
                bus.start           = 1'b1;
            end
            if (i == 2) begin
                bus.start = 1'b0;
                chk("ign_busy", 32'(bus.busy), 32'd1);
            end
            if (bus.done) break;
        end
        chk("ign_done_seen", 32'(bus.done), 32'd1);
        chk("ign_lat", 32'(c), 32'd4);
        chk("ign_mant", 32'(bus.mantice_out), 32'hFFE000);
        chk("ign_cnt", 32'(bus.shift_cnt), 32'd10);

        // Asynchronous reset in the middle of an align.
        @(negedge clk);
        bus.mode            = 2'b00;
        bus.parin_mantice   = 24'hFFFFFF;
        bus.shamt           = 8'd40;
        bus.serin_from_left = 1'b0;
        bus.start           = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_mant", 32'(bus.mantice_out), 32'd0);
        chk("abort_grs",  32'(bus.grs), 32'd0);
        chk("abort_cnt",  32'(bus.shift_cnt), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_nodone%0d", i), 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        v = '{2'b10, 24'h13579B, 8'd7, 1'b1, 1, 24'h13579B, 3'b000, 8'd0, 1'b0};
        run_op("post_rst", v);

        // shift_cnt saturation on the 3-bit count instance: 23 positions clamp to 7.
        @(negedge clk);
        bus2.mode          = 2'b01;
        bus2.parin_mantice = 24'h000001;
        bus2.start         = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        c = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            c = i;
            if (bus2.done) break;
        end
        chk("sat_done_seen", 32'(bus2.done), 32'd1);
        chk("sat_lat", 32'(c), 32'd7);
        chk("sat_mant", 32'(bus2.mantice_out), 32'h800000);
        chk("sat_cnt", 32'(bus2.shift_cnt), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mantissa_shift_unit.md
MANTISSA_SHIFT_UNIT -- requirements
Module: mantissa_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 24: mantissa width in bits.
REQ-002 SHALL have parameter STEP, default 4: maximum bit positions shifted per cycle (1..WIDTH).
REQ-003 SHALL have parameter CNT_W, default 8: width of shift-amount and shift-count fields.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  begin an operation; sampled only in IDLE.
REQ-008 mode  input  2  00 align-right, 01 normalize-left, 10/11 load-only.
REQ-009 parin_mantice  input  WIDTH  operand loaded on accepted start.
REQ-010 shamt  input  CNT_W  right-shift amount for align mode.
REQ-011 serin_from_left  input  1  fill bit for every MSB vacated by a right shift; sampled at start.
REQ-012 mantice_out  output  WIDTH  working mantissa register.
REQ-013 grs  output  3  guard, round, sticky bits below the LSB.
REQ-014 shift_cnt  output  CNT_W  total positions shifted in the current/last operation.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 zero  output  1  high with done when normalize found an all-zero operand.

Function
REQ-018 SHALL implement FSM states IDLE, ALIGN, NORM, DONE.
REQ-019 IDLE + start: load mantice_out=parin_mantice, grs=0, shift_cnt=0, remaining=shamt, latch fill bit; go to ALIGN (mode 00), NORM (01), DONE (10/11).
REQ-020 start outside IDLE SHALL be ignored, with no effect on state or data.
REQ-021 ALIGN, remaining=0: go to DONE, no shift.
REQ-022 ALIGN, remaining>0: shift {mantice_out,G,R} right by k=min(STEP,remaining); vacated MSBs = latched fill bit; sticky |= all bits shifted past R; remaining -= k; shift_cnt += k.
REQ-023 Align latency: done SHALL assert ceil(shamt/STEP)+1 cycles after the start edge.
REQ-024 shamt >= WIDTH+2: all original bits end in sticky; mantice_out = all fill bits; no overflow of internal datapath.
REQ-025 NORM, mantice_out=0 and G=R=0: go to DONE with zero=1 and shift_cnt unchanged.
REQ-026 NORM, MSB=1: go to DONE.
REQ-027 NORM otherwise: shift {mantice_out,G,R} left by k=min(STEP,leading zeros of mantice_out); zeros fill R; sticky unchanged; shift_cnt += k.
REQ-028 shift_cnt SHALL saturate at 2^CNT_W-1.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; outputs hold until the next accepted start.
REQ-030 zero SHALL be cleared on every accepted start.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, mantice_out=0, grs=0, shift_cnt=0, busy=0, done=0, zero=0, remaining=0.
REQ-032 Reset mid-operation SHALL abort it with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-033 Package mantissa_shift_pkg SHALL hold the FSM state enum and mode encodings (MODE_ALIGN, MODE_NORM, MODE_LOAD).
REQ-034 Leading-zero count SHALL be a sub-module mantissa_lzc (parameter WIDTH, output sized clog2(WIDTH+1)).
REQ-035 Per-cycle shifter SHALL be a STEP-limited combinational shift; full-width barrel shifting across WIDTH is not permitted.

Verification
REQ-036 Align: WIDTH=24, STEP=4, parin=0x800001, shamt=10, fill=1 -> done 4 cycles after start; mantice_out=0xFFE000; G=0, R=0, S=1; shift_cnt=10.
REQ-037 Normalize: parin=0x000300 -> shifts 4,4,4,2; done 5 cycles after start; mantice_out=0xC00000; shift_cnt=14; zero=0.
REQ-038 Normalize zero: parin=0 -> done 2 cycles after start; zero=1; shift_cnt=0.
REQ-039 Large align: parin=0xFFFFFF, shamt=40, fill=0 -> mantice_out=0, G=R=0, S=1, shift_cnt=40.
REQ-040 Busy/abort: start pulsed while busy -> ignored; rst low mid-ALIGN -> all outputs 0, no done; next start (mode 10) -> done after 1 cycle with mantice_out=parin.
REQ-041 shamt=0 align -> done 1 cycle after start; mantice_out=parin; grs=0.
